// File: rtl/instruction_fetch.sv
// RV32I fetch stage: keeps the fetch PC, reads instruction memory over
// req/ack and hands registered instruction/PC words to decode.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mem_req, mem_addr         registered read request and word address
//   mem_ack, mem_rdata        one-cycle completion pulse and returned word
//   instr_ready               decode accepts the presented word
//   instr_valid, instruction  registered word for decode (NOP when idle)
//   instr_pc                  address of the presented word
//   redirect, redirect_pc     taken branch/jump pulse and its target
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] fetch_pc;
  logic [31:0] pc_n;
  logic        req_n;
  logic [31:0] addr_n;
  logic        valid_n;
  logic [31:0] instr_n;
  logic [31:0] ipc_n;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign target = {redirect_pc[31:2], 2'b00};
  assign pc_inc = fetch_pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      fetch_pc    <= START_PC;
      mem_req     <= 1'b0;
      mem_addr    <= START_PC;
      instr_valid <= 1'b0;
      instruction <= NOP_INSTR;
      instr_pc    <= START_PC;
    end else begin
      state       <= state_n;
      fetch_pc    <= pc_n;
      mem_req     <= req_n;
      mem_addr    <= addr_n;
      instr_valid <= valid_n;
      instruction <= instr_n;
      instr_pc    <= ipc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    req_n   = mem_req;
    addr_n  = mem_addr;
    valid_n = instr_valid;
    instr_n = instruction;
    ipc_n   = instr_pc;

    unique case (state)
      FETCH: begin
        if (redirect) begin
          pc_n = target;
          if (!mem_req) begin
            // Nothing on the bus yet: issue straight to the target.
            req_n  = 1'b1;
            addr_n = target;
          end else if (mem_ack) begin
            // Word belongs to the squashed path; drop it.
            req_n = 1'b0;
          end else begin
            // Bus request cannot be aborted; wait it out.
            state_n = DISCARD;
          end
        end else if (!mem_req) begin
          req_n  = 1'b1;
          addr_n = fetch_pc;
        end else if (mem_ack) begin
          instr_n = mem_rdata;
          ipc_n   = fetch_pc;
          valid_n = 1'b1;
          pc_n    = pc_inc;
          req_n   = 1'b0;
          state_n = HOLD;
        end
      end

      HOLD: begin
        // A redirect voids any handshake in the same cycle.
        if (redirect) begin
          pc_n    = target;
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
          state_n = FETCH;
        end else if (instr_ready) begin
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
          state_n = FETCH;
        end
      end

      DISCARD: begin
        if (redirect) begin
          pc_n = target;
        end
        if (mem_ack) begin
          req_n   = 1'b0;
          state_n = FETCH;
        end
      end

      default: begin
        state_n = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, sequential fetch,
// backpressure, redirects and PC wrap on a second instance.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        rst2;
  logic        mem_req2;
  logic [31:0] mem_addr2;
  logic        mem_ack2;
  logic [31:0] mem_rdata2;
  logic        instr_ready2;
  logic        instr_valid2;
  logic [31:0] instruction2;
  logic [31:0] instr_pc2;
  logic        redirect2;
  logic [31:0] redirect_pc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_ready (instr_ready),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk         (clk),
    .rst         (rst2),
    .mem_req     (mem_req2),
    .mem_addr    (mem_addr2),
    .mem_ack     (mem_ack2),
    .mem_rdata   (mem_rdata2),
    .instr_ready (instr_ready2),
    .instr_valid (instr_valid2),
    .instruction (instruction2),
    .instr_pc    (instr_pc2),
    .redirect    (redirect2),
    .redirect_pc (redirect_pc2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst2 = 1'b1; mem_ack2 = 1'b0; mem_rdata2 = '0;
    instr_ready2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0;

    // 1: reset, then reset again mid-FETCH
    tick(); tick();
    rst = 1'b0;
    check("rst_req", {31'b0, mem_req}, 32'd0);
    tick();
    check("first_req", {31'b0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("midrst_req", {31'b0, mem_req}, 32'd0);
    check("midrst_valid", {31'b0, instr_valid}, 32'd0);
    check("midrst_instr", instruction, NOP);
    check("midrst_addr", mem_addr, 32'h0);
    tick();
    rst = 1'b0;
    check("rel_req", {31'b0, mem_req}, 32'd0);
    tick();
    check("rel_req1", {31'b0, mem_req}, 32'd1);
    check("rel_addr", mem_addr, 32'h0);

    // 2: sequential fetch with ready=1
    mem_ack = 1'b1; mem_rdata = 32'h0020_8193;
    tick();
    mem_ack = 1'b0; instr_ready = 1'b1;
    check("w0_valid", {31'b0, instr_valid}, 32'd1);
    check("w0_instr", instruction, 32'h0020_8193);
    check("w0_pc", instr_pc, 32'h0);
    check("w0_req", {31'b0, mem_req}, 32'd0);
    tick();
    check("w0_drop", {31'b0, instr_valid}, 32'd0);
    check("w0_nop", instruction, NOP);
    tick();
    check("w1_req", {31'b0, mem_req}, 32'd1);
    check("w1_addr", mem_addr, 32'h4);
    mem_ack = 1'b1; mem_rdata = 32'h40A5_8FB3;
    tick();
    mem_ack = 1'b0; instr_ready = 1'b0;
    check("w1_valid", {31'b0, instr_valid}, 32'd1);
    check("w1_instr", instruction, 32'h40A5_8FB3);
    check("w1_pc", instr_pc, 32'h4);

    // 3: backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'b0, instr_valid}, 32'd1);
      check("bp_instr", instruction, 32'h40A5_8FB3);
      check("bp_pc", instr_pc, 32'h4);
      check("bp_req", {31'b0, mem_req}, 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("bp_rel", {31'b0, instr_valid}, 32'd0);
    tick();
    check("w2_req", {31'b0, mem_req}, 32'd1);
    check("w2_addr", mem_addr, 32'h8);

    // 5: redirect while request at 0x8 is outstanding
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("disc_req", {31'b0, mem_req}, 32'd1);
      check("disc_addr", mem_addr, 32'h8);
      check("disc_valid", {31'b0, instr_valid}, 32'd0);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    check("disc_done", {31'b0, mem_req}, 32'd0);
    check("disc_novalid", {31'b0, instr_valid}, 32'd0);
    check("disc_instr", instruction, NOP);
    tick();
    check("tgt_req", {31'b0, mem_req}, 32'd1);
    check("tgt_addr", mem_addr, 32'h40);
    mem_ack = 1'b1; mem_rdata = 32'h0010_0093;
    tick();
    mem_ack = 1'b0;
    check("tgt_valid", {31'b0, instr_valid}, 32'd1);
    check("tgt_pc", instr_pc, 32'h40);

    // 4: redirect in HOLD to 0x103 with ready high (void handshake)
    redirect = 1'b1; redirect_pc = 32'h103; instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    check("hold_rd_valid", {31'b0, instr_valid}, 32'd0);
    check("hold_rd_instr", instruction, NOP);
    tick();
    check("hold_rd_req", {31'b0, mem_req}, 32'd1);
    check("hold_rd_addr", mem_addr, 32'h100);

    // redirect with ack in the same cycle: word dropped
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    mem_ack = 1'b0; redirect = 1'b0;
    check("ackrd_valid", {31'b0, instr_valid}, 32'd0);
    check("ackrd_req", {31'b0, mem_req}, 32'd0);
    tick();
    check("ackrd_addr", mem_addr, 32'h200);
    check("ackrd_req1", {31'b0, mem_req}, 32'd1);

    // ack while in HOLD is ignored
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    mem_rdata = 32'h3333_3333;
    tick();
    mem_ack = 1'b0;
    check("holdack_instr", instruction, 32'h2222_2222);
    check("holdack_pc", instr_pc, 32'h200);
    check("holdack_req", {31'b0, mem_req}, 32'd0);

    // 6: PC wrap on the RESET_PC=0xFFFFFFFC instance
    check("wrap_rst_addr", mem_addr2, 32'hFFFF_FFFC);
    check("wrap_rst_pc", instr_pc2, 32'hFFFF_FFFC);
    rst2 = 1'b0;
    tick();
    check("wrap_req", {31'b0, mem_req2}, 32'd1);
    check("wrap_addr", mem_addr2, 32'hFFFF_FFFC);
    mem_ack2 = 1'b1; mem_rdata2 = 32'h0000_0093;
    tick();
    mem_ack2 = 1'b0; instr_ready2 = 1'b1;
    check("wrap_valid", {31'b0, instr_valid2}, 32'd1);
    check("wrap_pc", instr_pc2, 32'hFFFF_FFFC);
    tick();
    instr_ready2 = 1'b0;
    tick();
    check("wrap_next_req", {31'b0, mem_req2}, 32'd1);
    check("wrap_next_addr", mem_addr2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
